// File: rtl/id_hazard_stage.sv
// rtl/id_hazard_stage.sv - decode stage with register file, load-use interlock and ID/EX register
// Optional same-cycle writeback forwarding into the operand read: define ID_WB_BYPASS_EN.
module id_hazard_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int NREG   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc_in,
  input  logic [XLEN-1:0]   pcPlus4_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [XLEN-1:0]   imm_in,
  input  logic              is_load_in,
  input  logic              wb_en,
  input  logic [4:0]        wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   pcPlus4_out,
  output logic [XLEN-1:0]   DataA_out,
  output logic [XLEN-1:0]   DataB_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [4:0]        AddrA_out,
  output logic [4:0]        AddrB_out,
  output logic [4:0]        AddrD_out,
  output logic [2:0]        funct3_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic              is_load_out,
  output logic              stall_out,
  output logic [15:0]       stall_cnt_out
);

  localparam logic [5:0] NREG_L = 6'(NREG);

  logic [XLEN-1:0] rf [NREG];
  logic [6:0]      opcode;
  logic            rs1_used, rs2_used;
  logic [4:0]      addr_a, addr_b;
  logic [XLEN-1:0] rd_a, rd_b;
  logic            wb_we, advance, hazard;
  logic            unused_inst_bits;

  // funct7 travels inside ctrl_in; the raw bits are not needed here
  assign unused_inst_bits = ^inst[31:25];

  assign opcode = inst[6:0];

  always_comb begin
    rs1_used = 1'b1;
    rs2_used = 1'b1;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: rs2_used = 1'b0;
      7'b1101111, 7'b0110111, 7'b0010111: begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
      end
      default: ;
    endcase
  end

  assign addr_a = rs1_used ? inst[19:15] : 5'd0;
  assign addr_b = rs2_used ? inst[24:20] : 5'd0;
  assign wb_we  = wb_en && (wb_addr != 5'd0) && ({1'b0, wb_addr} < NREG_L);

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (addr_a != 5'd0 && {1'b0, addr_a} < NREG_L) rd_a = rf[addr_a];
    if (addr_b != 5'd0 && {1'b0, addr_b} < NREG_L) rd_b = rf[addr_b];
`ifdef ID_WB_BYPASS_EN
    if (wb_we && wb_addr == addr_a) rd_a = wb_data;
    if (wb_we && wb_addr == addr_b) rd_b = wb_data;
`endif
  end

  // masked addresses are 0 when unused, so they can never match a nonzero rd
  assign hazard    = in_valid && out_valid && is_load_out && (AddrD_out != 5'd0) &&
                     ((addr_a == AddrD_out) || (addr_b == AddrD_out));
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = flush | (advance & ~hazard);
  assign stall_out = in_valid & ~in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wb_we) begin
      rf[wb_addr] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      pc_out        <= '0;
      pcPlus4_out   <= '0;
      DataA_out     <= '0;
      DataB_out     <= '0;
      imm_out       <= '0;
      AddrA_out     <= '0;
      AddrB_out     <= '0;
      AddrD_out     <= '0;
      funct3_out    <= '0;
      ctrl_out      <= '0;
      is_load_out   <= 1'b0;
      stall_cnt_out <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (advance) begin
        out_valid <= in_valid & ~hazard;
        if (in_valid && !hazard) begin
          pc_out      <= pc_in;
          pcPlus4_out <= pcPlus4_in;
          DataA_out   <= rd_a;
          DataB_out   <= rd_b;
          imm_out     <= imm_in;
          AddrA_out   <= addr_a;
          AddrB_out   <= addr_b;
          AddrD_out   <= inst[11:7];
          funct3_out  <= inst[14:12];
          ctrl_out    <= ctrl_in;
          is_load_out <= is_load_in;
        end
      end
      if (stall_out && hazard && stall_cnt_out != 16'hFFFF)
        stall_cnt_out <= stall_cnt_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_hazard_stage.sv
// tb/tb_id_hazard_stage.sv - directed self-checking bench for id_hazard_stage
module tb_id_hazard_stage;

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready;
  logic [31:0] inst, pc_in, pcPlus4_in, imm_in;
  logic [15:0] ctrl_in;
  logic        is_load_in, wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] pc_out, pcPlus4_out, DataA_out, DataB_out, imm_out;
  logic [4:0]  AddrA_out, AddrB_out, AddrD_out;
  logic [2:0]  funct3_out;
  logic [15:0] ctrl_out;
  logic        is_load_out, stall_out;
  logic [15:0] stall_cnt_out;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  id_hazard_stage dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .pc_in(pc_in), .pcPlus4_in(pcPlus4_in), .ctrl_in(ctrl_in), .imm_in(imm_in),
    .is_load_in(is_load_in), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .pcPlus4_out(pcPlus4_out), .DataA_out(DataA_out), .DataB_out(DataB_out),
    .imm_out(imm_out), .AddrA_out(AddrA_out), .AddrB_out(AddrB_out), .AddrD_out(AddrD_out),
    .funct3_out(funct3_out), .ctrl_out(ctrl_out), .is_load_out(is_load_out),
    .stall_out(stall_out), .stall_cnt_out(stall_cnt_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  task automatic present(input logic [31:0] ins, input logic ld, input logic [31:0] pc);
    in_valid   = 1'b1;
    inst       = ins;
    is_load_in = ld;
    pc_in      = pc;
    pcPlus4_in = pc + 32'd4;
    imm_in     = {{20{ins[31]}}, ins[31:20]};
    ctrl_in    = pc[15:0] ^ 16'h5A00;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    inst = r_add(5'd6, 5'd5, 5'd7); pc_in = 32'h40; pcPlus4_in = 32'h44; imm_in = 32'hFFFF;
    ctrl_in = 16'hBEEF; is_load_in = 1'b1;
    write_reg(5'd5, 32'hDEAD);
    tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt_out}, 32'd0);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_ctrl_out", {16'd0, ctrl_out}, 32'd0);
    check("rst_addrd", {27'd0, AddrD_out}, 32'd0);

    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; is_load_in = 1'b0;
    write_reg(5'd5, 32'h1234); tick();
    write_reg(5'd7, 32'h1);    tick();
    wb_en = 1'b0;
    present(r_add(5'd6, 5'd5, 5'd7), 1'b0, 32'h100);
    #1 check("add_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("add_out_valid", {31'd0, out_valid}, 32'd1);
    check("add_dataA", DataA_out, 32'h1234);
    check("add_dataB", DataB_out, 32'h1);
    check("add_addrD", {27'd0, AddrD_out}, 32'd6);
    check("add_pc4", pcPlus4_out, 32'h104);
    check("add_ctrl", {16'd0, ctrl_out}, 32'h5B00);
    in_valid = 1'b0; tick();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    // load-use interlock
    present(i_lw(5'd5, 5'd2), 1'b1, 32'h104);
    tick();
    check("lw_is_load", {31'd0, is_load_out}, 32'd1);
    check("lw_addrB", {27'd0, AddrB_out}, 32'd0);
    check("lw_funct3", {29'd0, funct3_out}, 32'd2);
    present(r_add(5'd6, 5'd5, 5'd1), 1'b0, 32'h108);
    #1 check("lu_in_ready", {31'd0, in_ready}, 32'd0);
    check("lu_stall", {31'd0, stall_out}, 32'd1);
    tick();
    check("lu_bubble", {31'd0, out_valid}, 32'd0);
    check("lu_cnt", {16'd0, stall_cnt_out}, 32'd1);
    check("lu_payload_hold", {27'd0, AddrD_out}, 32'd5);
    tick();
    check("lu_issue_valid", {31'd0, out_valid}, 32'd1);
    check("lu_issue_addrD", {27'd0, AddrD_out}, 32'd6);
    check("lu_issue_dataA", DataA_out, 32'h1234);
    check("lu_cnt_after", {16'd0, stall_cnt_out}, 32'd1);

    // unused rs2 and x0 destinations never interlock
    present(i_lw(5'd5, 5'd2), 1'b1, 32'h10C);
    tick();
    present(i_addi(5'd3, 5'd0, 12'd5), 1'b0, 32'h110);
    #1 check("addi_no_stall", {31'd0, in_ready}, 32'd1);
    check("addi_stall_out", {31'd0, stall_out}, 32'd0);
    tick();
    check("addi_addrD", {27'd0, AddrD_out}, 32'd3);
    check("addi_addrB", {27'd0, AddrB_out}, 32'd0);
    check("addi_imm", imm_out, 32'd5);
    present(i_lw(5'd0, 5'd2), 1'b1, 32'h114);
    tick();
    present(r_add(5'd7, 5'd0, 5'd0), 1'b0, 32'h118);
    #1 check("lw_x0_no_stall", {31'd0, in_ready}, 32'd1);
    tick();
    check("after_lw_x0_addrD", {27'd0, AddrD_out}, 32'd7);

    // backpressure
    out_ready = 1'b0;
    present(i_addi(5'd8, 5'd0, 12'd1), 1'b0, 32'h200);
    #1 check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_stall_out", {31'd0, stall_out}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      check("bp_addrD_hold", {27'd0, AddrD_out}, 32'd7);
      check("bp_pc_hold", pc_out, 32'h118);
    end
    out_ready = 1'b1;
    #1 check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    check("bp_first_addrD", {27'd0, AddrD_out}, 32'd8);
    check("bp_first_pc", pc_out, 32'h200);
    present(i_addi(5'd9, 5'd0, 12'd2), 1'b0, 32'h204);
    tick();
    check("bp_second_addrD", {27'd0, AddrD_out}, 32'd9);
    in_valid = 1'b0; tick();
    check("bp_drain", {31'd0, out_valid}, 32'd0);
    check("bp_cnt", {16'd0, stall_cnt_out}, 32'd1);

    // flush overrides a pending hazard
    present(i_lw(5'd5, 5'd2), 1'b1, 32'h300);
    tick();
    present(r_add(5'd6, 5'd5, 5'd1), 1'b0, 32'h304);
    flush = 1'b1;
    #1 check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    check("fl_stall_out", {31'd0, stall_out}, 32'd0);
    tick();
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_cnt", {16'd0, stall_cnt_out}, 32'd1);
    check("fl_addrD_hold", {27'd0, AddrD_out}, 32'd5);
    flush = 1'b0; in_valid = 1'b0;

    // writeback in the same cycle as the read
    write_reg(5'd9, 32'h11); tick();
    write_reg(5'd9, 32'hA5);
    present(r_add(5'd10, 5'd9, 5'd0), 1'b0, 32'h400);
    tick();
`ifdef ID_WB_BYPASS_EN
    check("wb_same_cycle", DataA_out, 32'hA5);
`else
    check("wb_same_cycle", DataA_out, 32'h11);
`endif
    wb_en = 1'b0;
    present(r_add(5'd11, 5'd9, 5'd0), 1'b0, 32'h404);
    tick();
    check("wb_next_cycle", DataA_out, 32'hA5);
    write_reg(5'd0, 32'hFF);
    present(r_add(5'd12, 5'd0, 5'd0), 1'b0, 32'h408);
    tick();
    check("x0_same_cycle", DataA_out, 32'd0);
    wb_en = 1'b0;
    present(r_add(5'd13, 5'd0, 5'd0), 1'b0, 32'h40C);
    tick();
    check("x0_next_cycle", DataA_out, 32'd0);

    // reset mid-stream clears pipeline and register file
    present(r_add(5'd1, 5'd5, 5'd7), 1'b0, 32'h500);
    reset_n = 1'b0;
    tick();
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_pc", pc_out, 32'd0);
    check("rst2_cnt", {16'd0, stall_cnt_out}, 32'd0);
    reset_n = 1'b1;
    tick();
    check("rst2_issue_valid", {31'd0, out_valid}, 32'd1);
    check("rst2_x5_cleared", DataA_out, 32'd0);
    check("rst2_x7_cleared", DataB_out, 32'd0);
    check("rst2_addrD", {27'd0, AddrD_out}, 32'd1);
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_hazard_stage.md
ID_HAZARD_STAGE -- requirements
Module: id_hazard_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of pc, operands, immediate and writeback data.
REQ-002 Parameter CTRL_W, default 16, width of the packed control bundle carried ID->EX.
REQ-003 Parameter NREG, default 32, register-file depth; address width fixed at 5 bits.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-006 flush  in  1  branch/jump redirect from EX; kills the instruction being accepted and the ID/EX register.
REQ-007 in_valid / in_ready  in / out  1 / 1  IF->ID handshake; transfer when both high.
REQ-008 inst  in  32  instruction word; pc_in, pcPlus4_in  in  XLEN  its PC and PC+4.
REQ-009 ctrl_in  in  CTRL_W  pre-decoded control bundle; imm_in  in  XLEN  generated immediate; is_load_in  in  1  instruction is a load.
REQ-010 wb_en, wb_addr, wb_data  in  1, 5, XLEN  register-file write port from WB.
REQ-011 out_valid / out_ready  out / in  1 / 1  ID->EX handshake.
REQ-012 pc_out, pcPlus4_out, DataA_out, DataB_out, imm_out  out  XLEN  registered payload.
REQ-013 AddrA_out, AddrB_out, AddrD_out  out  5; funct3_out  out  3; ctrl_out  out  CTRL_W; is_load_out  out  1.
REQ-014 stall_out  out  1  combinational: in_valid & ~in_ready & ~flush.
REQ-015 stall_cnt_out  out  16  count of load-use stall cycles, saturating at 0xFFFF.

Function
REQ-016 rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7], funct3 = inst[14:12].
REQ-017 rs2 unused for opcodes 0010011, 0000011, 1101111, 1100111, 0110111, 0010111; rs1 unused for 1101111, 0110111, 0010111; an unused address SHALL be forced to 0.
REQ-018 Register file: NREG x XLEN; write on rising edge when wb_en & wb_addr!=0; x0 reads 0 always; addresses >= NREG read 0 and are not written.
REQ-019 advance = ~out_valid | out_ready.
REQ-020 hazard = in_valid & out_valid & is_load_out & AddrD_out!=0 & ((rs1 used & rs1==AddrD_out) | (rs2 used & rs2==AddrD_out)).
REQ-021 in_ready = flush | (advance & ~hazard).
REQ-022 flush has priority: next cycle out_valid=0, incoming instruction discarded, hazard ignored.
REQ-023 hazard & advance & ~flush: bubble inserted, out_valid=0 next cycle; payload registers hold.
REQ-024 Normal advance: out_valid <= in_valid; payload captured only when in_valid & in_ready; latency inst->outputs exactly 1 cycle.
REQ-025 ~advance & ~flush: all output registers hold (backpressure), no instruction lost or duplicated.
REQ-026 stall_cnt_out increments by 1 each cycle stall_out & hazard is high; holds at 0xFFFF.
REQ-027 Payload is captured only on accepted transfers and holds otherwise; bubble and flush affect only out_valid.

Reset
REQ-028 reset_n=0 at a rising edge: out_valid=0, stall_cnt_out=0, every payload output=0, all register-file entries=0.
REQ-029 Reset overrides flush, wb_en and any in-flight handshake; in_ready in reset cycle is don't-care, first valid transfer occurs no earlier than the cycle after reset_n rises.

Configuration
REQ-030 Macro ID_WB_BYPASS_EN defined: if wb_en & wb_addr!=0 & wb_addr matches used rs1/rs2 in the same cycle, DataA/DataB captured SHALL be wb_data (write-first).
REQ-031 ID_WB_BYPASS_EN undefined: operands read the pre-write register value; wb_data visible only from the next cycle.

Verification
REQ-032 Reset, then wb x5=0x1234, issue ADD x6,x5,x7 (x7=1) with out_ready=1 -> next cycle out_valid=1, DataA_out=0x1234, DataB_out=1, AddrD_out=6.
REQ-033 LW x5 accepted, next cycle ADD x6,x5,x1 in_valid -> in_ready=0, stall_out=1, one bubble (out_valid=0), ADD issued following cycle, stall_cnt_out=1.
REQ-034 ADDI x3,x5,4 after LW x5 -> AddrB_out=0, rs2 ignored, LW x5 with ADDI x3,x0,4 or LW x0 -> no stall.
REQ-035 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; on release exactly one transfer per cycle, no loss.
REQ-036 flush=1 coincident with hazard and in_valid -> in_ready=1, out_valid=0 next cycle, stall_cnt_out unchanged.
REQ-037 wb_en x9=0xA5 same cycle ADD reads x9 -> DataA_out=0xA5 with ID_WB_BYPASS_EN, old value without; write to x0 -> x0 still reads 0.
